eth_tx_mii_serializer: RTL and testbench

- Transmit back-end of the Ethernet MAC, in the MTxClk domain.
- Consumes 32-bit frame words from the TX fetch path (APB-master memory reads into a buffer) over a valid/ready handshake.
- Drives the MII transmit pins MTxD/MTxEn/MTxErr and defers to MCrS.
- Generates preamble/SFD, serializes data low nibble first, optionally appends FCS, enforces inter-frame gap.

---
 rtl/eth_tx_pkg.sv | 42 ++++
 rtl/eth_crc32_nibble.sv | 25 ++
 rtl/eth_tx_mii_serializer.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_tx_mii_serializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared types and constants for the Ethernet MII transmit serializer.
//   tx_state_e      : serializer state encoding
//   PREAMBLE_NIBBLE : nibble repeated during the preamble
//   SFD_NIBBLE      : start-of-frame delimiter nibble
//   CRC_POLY        : IEEE 802.3 CRC-32 polynomial (normal form)
//   CRC_INIT        : CRC-32 preset value
//   CRC_POLY_REFL   : reflected polynomial used by the LSB-first CRC engine
//   word_nibbles()  : number of nibbles carried by a frame word
// -----------------------------------------------------------------------------
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_FCS      = 3'd3,
    ST_IFG      = 3'd4
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] value);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = value[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  // A last word carries 'bytes' bytes (0 encodes a full word); every other
  // word is full. Two nibbles per byte.
  function automatic logic [3:0] word_nibbles(input logic last, input logic [1:0] bytes);
    if (last && bytes != 2'd0) return {1'b0, bytes, 1'b0};
    return 4'd8;
  endfunction

endpackage

// File: rtl/eth_crc32_nibble.sv
// -----------------------------------------------------------------------------
// eth_crc32_nibble
// Combinational one-nibble step of the reflected Ethernet CRC-32.
//   crc      : current CRC register value
//   nibble   : data nibble, bit 0 is the first bit on the wire
//   crc_next : CRC after absorbing the nibble
// -----------------------------------------------------------------------------
module eth_crc32_nibble
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  always_comb begin
    logic [31:0] c;
    c = crc ^ {28'h0, nibble};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_tx_mii_serializer.sv
// -----------------------------------------------------------------------------
// eth_tx_mii_serializer
// MII transmit back-end: takes 32-bit frame words over valid/ready, emits
// preamble + SFD, serializes data low nibble first, optionally appends the
// FCS, then holds the line idle for the inter-frame gap. Defers to carrier
// sense only while idle.
//
// Build option: define TX_CRC_EN to compute the CRC-32 over the data nibbles
// and append it as an 8-nibble FCS. Without it the frame ends after the data.
//
// Ports
//   MTxClk        in   MII transmit clock, all logic on its rising edge
//   rst_i         in   asynchronous active-high reset
//   tx_data_i     in   frame word, bits[7:0] transmitted first
//   tx_bytes_i    in   valid bytes of a last word (0 means 4)
//   tx_last_i     in   word is the final word of the frame
//   tx_valid_i    in   word present
//   tx_ready_o    out  word accepted when valid and ready are both high
//   MCrS          in   carrier sense
//   MTxD          out  transmit nibble
//   MTxEn         out  transmit enable
//   MTxErr        out  transmit error
//   tx_done_o     out  one-cycle pulse on normal frame completion
//   tx_underrun_o out  one-cycle pulse when a frame is aborted by underrun
// -----------------------------------------------------------------------------
module eth_tx_mii_serializer
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic        MTxClk,
  input  logic        rst_i,
  input  logic [31:0] tx_data_i,
  input  logic [1:0]  tx_bytes_i,
  input  logic        tx_last_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic        MCrS,
  output logic [3:0]  MTxD,
  output logic        MTxEn,
  output logic        MTxErr,
  output logic        tx_done_o,
  output logic        tx_underrun_o
);

  // One shared counter: preamble position, nibble index within the word,
  // FCS nibble index or IFG cycle count, depending on the state.
  localparam int CNT_MAX = (IFG_NIBBLES > PREAMBLE_NIBBLES) ? IFG_NIBBLES : PREAMBLE_NIBBLES;
  localparam int CNT_TOP = (CNT_MAX > 8) ? CNT_MAX : 8;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PRE_LAST = cnt_t'(PREAMBLE_NIBBLES);
  localparam cnt_t IFG_LAST = cnt_t'(IFG_NIBBLES - 1);

  // The state and all registered outputs describe the cycle currently on the
  // pins; the comb block computes what the next cycle shows.
  tx_state_e   state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] data_q, data_d;     // nibbles still to send, next one in [3:0]
  logic [1:0]  bytes_q, bytes_d;
  logic        last_q, last_d;
  logic [3:0]  txd_d;
  logic        en_d, err_d, ready_d, done_d, underrun_d;
  logic        accept;
  cnt_t        final_idx;

  assign accept    = tx_valid_i & tx_ready_o;
  assign final_idx = cnt_t'(word_nibbles(last_q, bytes_q) - 4'd1);

`ifdef TX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_upd, fcs;

  assign fcs = ~crc_q;

  eth_crc32_nibble u_crc (
    .crc      (crc_q),
    .nibble   (txd_d),
    .crc_next (crc_upd)
  );

  always_comb begin
    crc_d = crc_q;
    if (state_d == ST_PREAMBLE) begin
      crc_d = CRC_INIT;
    end else if (state_d == ST_DATA && en_d && !err_d) begin
      crc_d = crc_upd;
    end
  end

  always_ff @(posedge MTxClk or posedge rst_i) begin
    if (rst_i) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    bytes_d    = bytes_q;
    last_d     = last_q;
    txd_d      = 4'h0;
    en_d       = 1'b0;
    err_d      = 1'b0;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = tx_data_i;
          bytes_d = tx_bytes_i;
          last_d  = tx_last_i;
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
          en_d    = 1'b1;
          txd_d   = (PRE_LAST == '0) ? SFD_NIBBLE : PREAMBLE_NIBBLE;
        end else begin
          // Carrier sense only gates acceptance; it is ignored once committed.
          ready_d = !MCrS;
        end
      end

      ST_PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          txd_d   = data_q[3:0];
          data_d  = {4'h0, data_q[31:4]};
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
          txd_d = (cnt_d == PRE_LAST) ? SFD_NIBBLE : PREAMBLE_NIBBLE;
        end
      end

      ST_DATA: begin
        if (tx_underrun_o) begin
          // The error cycle has been shown; the gap starts now.
          state_d = ST_IFG;
          cnt_d   = '0;
        end else if (cnt_q != final_idx) begin
          en_d    = 1'b1;
          cnt_d   = cnt_q + cnt_t'(1);
          txd_d   = data_q[3:0];
          data_d  = {4'h0, data_q[31:4]};
          // Ready rises on the final nibble of a non-last word so the next
          // word can follow without a gap.
          ready_d = !last_q && (cnt_d == cnt_t'(7));
        end else if (!last_q) begin
          en_d = 1'b1;
          if (accept) begin
            cnt_d   = '0;
            bytes_d = tx_bytes_i;
            last_d  = tx_last_i;
            txd_d   = tx_data_i[3:0];
            data_d  = {4'h0, tx_data_i[31:4]};
          end else begin
            err_d      = 1'b1;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
`ifdef TX_CRC_EN
          state_d = ST_FCS;
          en_d    = 1'b1;
          txd_d   = fcs[3:0];
          data_d  = {4'h0, fcs[31:4]};
`else
          state_d = ST_IFG;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef TX_CRC_EN
      ST_FCS: begin
        if (cnt_q == cnt_t'(7)) begin
          state_d = ST_IFG;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          en_d   = 1'b1;
          cnt_d  = cnt_q + cnt_t'(1);
          txd_d  = data_q[3:0];
          data_d = {4'h0, data_q[31:4]};
        end
      end
`endif

      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge MTxClk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      // NOTE: the word buffer is a plain register, so it is reset along with
      // the control state; this makes the mid-frame discard explicit.
      data_q        <= '0;
      bytes_q       <= 2'd0;
      last_q        <= 1'b0;
      MTxD          <= 4'h0;
      MTxEn         <= 1'b0;
      MTxErr        <= 1'b0;
      tx_ready_o    <= 1'b0;
      tx_done_o     <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      bytes_q       <= bytes_d;
      last_q        <= last_d;
      MTxD          <= txd_d;
      MTxEn         <= en_d;
      MTxErr        <= err_d;
      tx_ready_o    <= ready_d;
      tx_done_o     <= done_d;
      tx_underrun_o <= underrun_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_mii_serializer.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_mii_serializer
// Directed self-checking bench for eth_tx_mii_serializer. Outputs are sampled
// on the falling edge; inputs change on the falling edge or just after the
// rising edge. Define TX_CRC_EN to match an FCS-enabled build of the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_tx_mii_serializer;

  localparam int PRE = 15;
  localparam int IFG = 24;

  logic        MTxClk = 1'b0;
  logic        rst_i;
  logic [31:0] tx_data_i;
  logic [1:0]  tx_bytes_i;
  logic        tx_last_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        MCrS;
  logic [3:0]  MTxD;
  logic        MTxEn;
  logic        MTxErr;
  logic        tx_done_o;
  logic        tx_underrun_o;

  eth_tx_mii_serializer #(
    .PREAMBLE_NIBBLES (PRE),
    .IFG_NIBBLES      (IFG)
  ) dut (
    .MTxClk        (MTxClk),
    .rst_i         (rst_i),
    .tx_data_i     (tx_data_i),
    .tx_bytes_i    (tx_bytes_i),
    .tx_last_i     (tx_last_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .MCrS          (MCrS),
    .MTxD          (MTxD),
    .MTxEn         (MTxEn),
    .MTxErr        (MTxErr),
    .tx_done_o     (tx_done_o),
    .tx_underrun_o (tx_underrun_o)
  );

  always #5 MTxClk = ~MTxClk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  bytes;
    logic        last;
  } word_t;

  word_t       wq[$];
  logic [3:0]  exp_q[$];
  logic        exp_rdy_q[$];
  logic [31:0] model_crc;
  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          urun_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse counters.
  always @(negedge MTxClk) begin
    if (tx_done_o === 1'b1)     done_cnt++;
    if (tx_underrun_o === 1'b1) urun_cnt++;
  end

  // Word driver: presents the head of wq; a word seen with ready high on a
  // falling edge is consumed by the following rising edge.
  initial begin : driver
    bit pend;
    pend       = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    tx_bytes_i = '0;
    tx_last_i  = 1'b0;
    forever begin
      @(negedge MTxClk);
      if (rst_i) pend = 1'b0;
      if (pend) begin
        if (wq.size() > 0) wq.delete(0);
        pend = 1'b0;
      end
      if (wq.size() > 0) begin
        tx_valid_i = 1'b1;
        tx_data_i  = wq[0].data;
        tx_bytes_i = wq[0].bytes;
        tx_last_i  = wq[0].last;
        pend       = (tx_ready_o === 1'b1) && !rst_i;
      end else begin
        tx_valid_i = 1'b0;
      end
    end
  end

  task automatic start_frame();
    exp_q.delete();
    exp_rdy_q.delete();
    model_crc = 32'hFFFFFFFF;
    for (int i = 0; i < PRE; i++) begin
      exp_q.push_back(4'h5);
      exp_rdy_q.push_back(1'b0);
    end
    exp_q.push_back(4'hD);
    exp_rdy_q.push_back(1'b0);
  endtask

  // Queues the word for the driver and appends its nibbles to the expected
  // stream; a bit-serial CRC model tracks the frame.
  task automatic add_word(input logic [31:0] data, input logic [1:0] bytes, input logic last);
    word_t w;
    int    n;
    w.data = data; w.bytes = bytes; w.last = last;
    wq.push_back(w);
    n = (last && bytes != 2'd0) ? 2 * int'(bytes) : 8;
    for (int i = 0; i < n; i++) begin
      logic [3:0] nib;
      nib = data[4*i +: 4];
      exp_q.push_back(nib);
      exp_rdy_q.push_back(!last && i == 7);
      for (int b = 0; b < 4; b++) begin
        logic fb;
        fb = model_crc[0] ^ nib[b];
        model_crc = model_crc >> 1;
        if (fb) model_crc = model_crc ^ 32'hEDB88320;
      end
    end
  endtask

  task automatic push_fcs(input logic [31:0] fcs);
`ifdef TX_CRC_EN
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(fcs[4*i +: 4]);
      exp_rdy_q.push_back(1'b0);
    end
`else
    if (fcs === 32'hx) exp_q.push_back(4'h0);
`endif
  endtask

  task automatic end_frame();
    push_fcs(~model_crc);
  endtask

  // Waits (bounded) for MTxEn, checks the wait length and ready activity
  // during the wait, then checks every nibble of the expected stream.
  task automatic check_frame(input string tag, input int exp_wait);
    int waited;
    int rdy;
    waited = 0;
    rdy    = 0;
    while (MTxEn !== 1'b1 && waited < 200) begin
      @(negedge MTxClk);
      waited++;
      if (tx_ready_o === 1'b1) rdy++;
    end
    check({tag, " start"}, waited, exp_wait);
    check({tag, " ready_during_wait"}, rdy, 1);
    if (MTxEn !== 1'b1) return;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge MTxClk);
      check($sformatf("%s nib%0d {en,err,rdy,d}", tag, i),
            {MTxEn, MTxErr, tx_ready_o, MTxD},
            {1'b1, 1'b0, exp_rdy_q[i], exp_q[i]});
    end
  endtask

  task automatic trailer(input string tag);
    @(negedge MTxClk);
    check({tag, " end {en,err,rdy,done,urun}"},
          {MTxEn, MTxErr, tx_ready_o, tx_done_o, tx_underrun_o}, 5'b00010);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0;
    int u0;
    int w;
    rst_i = 1'b1;
    MCrS  = 1'b0;

    // Reset values.
    repeat (3) @(negedge MTxClk);
    check("rst MTxD", MTxD, 4'h0);
    check("rst MTxEn", MTxEn, 1'b0);
    check("rst MTxErr", MTxErr, 1'b0);
    check("rst ready", tx_ready_o, 1'b0);
    check("rst done", tx_done_o, 1'b0);
    check("rst underrun", tx_underrun_o, 1'b0);
    rst_i = 1'b0;

    // Single full last word, then a multi-word frame queued back to back.
    start_frame();
    add_word(32'h44332211, 2'd0, 1'b1);
    end_frame();
    check_frame("single", 2);
    trailer("single");

    start_frame();
    add_word(32'h34333231, 2'd0, 1'b0);
    add_word(32'h38373635, 2'd0, 1'b0);
    add_word(32'h00000039, 2'd1, 1'b1);
    push_fcs(32'hCBF43926);
    check_frame("b2b", IFG + 2);
    trailer("b2b");

    // Underrun: one non-last word and nothing after it.
    start_frame();
    add_word(32'hAABBCCDD, 2'd0, 1'b0);
    check_frame("urun", IFG + 2);
    @(negedge MTxClk);
    check("urun err {en,err,d}", {MTxEn, MTxErr, MTxD}, 6'b110000);
    check("urun pulse", tx_underrun_o, 1'b1);
    check("urun no done", tx_done_o, 1'b0);
    @(negedge MTxClk);
    check("urun after {en,err,urun}", {MTxEn, MTxErr, tx_underrun_o}, 3'b000);
    repeat (30) @(negedge MTxClk);
    check("done pulses so far", done_cnt, 2);
    check("underrun pulses so far", urun_cnt, 1);

    // Deferral: carrier sense high with a word waiting.
    MCrS = 1'b1;
    @(negedge MTxClk);
    start_frame();
    add_word(32'hDEADBEEF, 2'd2, 1'b1);
    end_frame();
    for (int i = 0; i < 10; i++) begin
      @(negedge MTxClk);
      check($sformatf("defer c%0d {rdy,en}", i), {tx_ready_o, MTxEn}, 2'b00);
    end
    MCrS = 1'b0;
    check_frame("defer", 2);
    trailer("defer");

    // Reset on data nibble 5, then an immediate new frame.
    repeat (30) @(negedge MTxClk);
    start_frame();
    add_word(32'h44332211, 2'd0, 1'b1);
    end_frame();
    w = 0;
    while (MTxEn !== 1'b1 && w < 100) begin
      @(negedge MTxClk);
      w++;
    end
    check("rstmid start", w, 2);
    repeat (PRE + 1 + 5) @(negedge MTxClk);
    check("rstmid nib5 {en,d}", {MTxEn, MTxD}, 5'b10011);
    d0 = done_cnt;
    u0 = urun_cnt;
    rst_i = 1'b1;
    #1;
    check("rstmid async {en,err}", {MTxEn, MTxErr}, 2'b00);
    check("rstmid pulses {done,urun}", {tx_done_o, tx_underrun_o}, 2'b00);
    wq.delete();
    repeat (2) @(negedge MTxClk);
    rst_i = 1'b0;
    start_frame();
    add_word(32'h12345678, 2'd3, 1'b1);
    end_frame();
    check_frame("after_rst", 2);
    trailer("after_rst");
    @(negedge MTxClk);
    check("rstmid done count", done_cnt - d0, 1);
    check("rstmid underrun count", urun_cnt - u0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
